// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the multicycle CPU exception
//               sequencer: state encoding, address-mux selects, cause codes
//               and handler vector addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Exception sequencer states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAVE_EPC = 3'd1,
        ST_VEC_RD   = 3'd2,
        ST_VEC_WAIT = 3'd3,
        ST_LOAD_PC  = 3'd4
    } exc_state_t;

    // Memory-address mux selects.
    localparam logic [2:0] IORD_PC      = 3'b000;
    localparam logic [2:0] IORD_S       = 3'b001;
    localparam logic [2:0] IORD_SAIDA   = 3'b010;
    localparam logic [2:0] IORD_VEC_OPC = 3'b011;
    localparam logic [2:0] IORD_VEC_OVF = 3'b100;
    localparam logic [2:0] IORD_VEC_DIV = 3'b101;

    // Latched exception cause codes.
    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OPC  = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;
    localparam logic [1:0] CAUSE_DIV0 = 2'b11;

    // Byte addresses holding the handler entry points.
    localparam logic [7:0] VEC_ADDR_OPC = 8'd253;
    localparam logic [7:0] VEC_ADDR_OVF = 8'd254;
    localparam logic [7:0] VEC_ADDR_DIV = 8'd255;

    // Result of exception arbitration.
    typedef struct packed {
        logic       valid;
        logic [1:0] cause;
        logic [2:0] vec_sel;
    } exc_req_t;

    // Controller selects 110/111 have no mux input behind them; park on PC.
    function automatic logic [2:0] iord_filter(input logic [2:0] sel);
        return (sel[2] && sel[1]) ? IORD_PC : sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/exc_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : exc_seq_if
// Description : Bundle between the main controller / datapath and the
//               exception sequencer. The slave modport is the sequencer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface exc_seq_if;

    logic [2:0] ctrl_iordmux;
    logic       exc_opcode;
    logic       exc_overflow;
    logic       exc_div0;
    logic [2:0] iordmux;
    logic       mem_read;
    logic       mdr_write;
    logic       epc_write;
    logic       pc_write;
    logic       pc_src_exc;
    logic       ctrl_hold;
    logic [1:0] cause;
    logic       exc_done;

    modport slave (
        input  ctrl_iordmux, exc_opcode, exc_overflow, exc_div0,
        output iordmux, mem_read, mdr_write, epc_write, pc_write,
               pc_src_exc, ctrl_hold, cause, exc_done
    );

    modport master (
        output ctrl_iordmux, exc_opcode, exc_overflow, exc_div0,
        input  iordmux, mem_read, mdr_write, epc_write, pc_write,
               pc_src_exc, ctrl_hold, cause, exc_done
    );

endinterface
`default_nettype wire

// File: rtl/exc_seq_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : exc_prio_enc
// Description : Fixed-priority exception arbiter. Invalid opcode beats
//               overflow beats divide-by-zero; losers are simply dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_prio_enc
    import cpu_pkg::*;
(
    input  wire logic i_exc_opcode,
    input  wire logic i_exc_overflow,
    input  wire logic i_exc_div0,
    output exc_req_t  o_req
);

    // Pick the highest-priority pending event and its vector select.
    always_comb begin
        o_req = '{valid: 1'b0, cause: CAUSE_NONE, vec_sel: IORD_PC};
        if (i_exc_opcode) begin
            o_req = '{valid: 1'b1, cause: CAUSE_OPC, vec_sel: IORD_VEC_OPC};
        end else if (i_exc_overflow) begin
            o_req = '{valid: 1'b1, cause: CAUSE_OVF, vec_sel: IORD_VEC_OVF};
        end else if (i_exc_div0) begin
            o_req = '{valid: 1'b1, cause: CAUSE_DIV0, vec_sel: IORD_VEC_DIV};
        end
    end

endmodule
`default_nettype wire

// File: rtl/exc_seq.sv
`default_nettype none
// ============================================================================
// Module      : exc_seq
// Description : Exception sequencer. On an accepted exception it saves EPC,
//               fetches the handler byte from the fixed vector location and
//               loads it into PC while stalling the main controller. When
//               idle it forwards the controller's address-mux select.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_seq
    import cpu_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1
)(
    input  wire logic  clk,
    input  wire logic  reset,
    exc_seq_if.slave   bus
);

    // Wait counter preload: VEC_WAIT lasts MEM_LATENCY cycles in total.
    localparam logic [2:0] C_CNT_LOAD = 3'(MEM_LATENCY - 1);

    exc_state_t r_state;
    exc_state_t w_state_nxt;
    logic [2:0] r_cnt;
    logic [1:0] r_cause;
    logic [2:0] r_vec;
    exc_req_t   w_req;

    exc_prio_enc u_prio (
        .i_exc_opcode   (bus.exc_opcode),
        .i_exc_overflow (bus.exc_overflow),
        .i_exc_div0     (bus.exc_div0),
        .o_req          (w_req)
    );

    // State register plus wait counter, cause and vector latches.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_cause <= CAUSE_NONE;
            r_vec   <= IORD_PC;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_req.valid) begin
                        r_cause <= w_req.cause;
                        r_vec   <= w_req.vec_sel;
                    end
                end
                ST_VEC_RD:   r_cnt <= C_CNT_LOAD;
                ST_VEC_WAIT: if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                default:     ;
            endcase
        end
    end

    // Next-state decode and Moore strobes; iordmux is the only input-driven path.
    always_comb begin
        w_state_nxt    = r_state;
        bus.iordmux    = IORD_PC;
        bus.mem_read   = 1'b0;
        bus.mdr_write  = 1'b0;
        bus.epc_write  = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src_exc = 1'b0;
        bus.exc_done   = 1'b0;
        bus.ctrl_hold  = 1'b1;
        case (r_state)
            ST_IDLE: begin
                bus.iordmux   = iord_filter(bus.ctrl_iordmux);
                bus.ctrl_hold = 1'b0;
                if (w_req.valid) w_state_nxt = ST_SAVE_EPC;
            end
            ST_SAVE_EPC: begin
                bus.epc_write = 1'b1;
                w_state_nxt   = ST_VEC_RD;
            end
            ST_VEC_RD: begin
                bus.iordmux  = r_vec;
                bus.mem_read = 1'b1;
                w_state_nxt  = ST_VEC_WAIT;
            end
            ST_VEC_WAIT: begin
                bus.iordmux  = r_vec;
                bus.mem_read = 1'b1;
                if (r_cnt == 3'd0) begin
                    bus.mdr_write = 1'b1;
                    w_state_nxt   = ST_LOAD_PC;
                end
            end
            ST_LOAD_PC: begin
                bus.pc_write   = 1'b1;
                bus.pc_src_exc = 1'b1;
                bus.exc_done   = 1'b1;
                w_state_nxt    = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.cause = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_exc_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_exc_seq
// Description : Directed scoreboard bench for exc_seq. Two instances, one at
//               MEM_LATENCY=1 and one at MEM_LATENCY=3. Each stimulus cycle
//               pushes the hand-derived outputs expected during that cycle;
//               a monitor pops and compares mid-cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_seq;

    typedef struct packed {
        logic [2:0] iord;
        logic       mr;
        logic       mw;
        logic       ew;
        logic       pw;
        logic       ps;
        logic       hold;
        logic [1:0] cause;
        logic       done;
    } exp_t;

    typedef struct packed {
        int   tag;
        exp_t e;
    } item_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step  = 0;
    item_t q1[$];
    item_t q3[$];

    always #5 clk = ~clk;

    exc_seq_if b1 ();
    exc_seq_if b3 ();

    exc_seq #(.MEM_LATENCY(1)) u_dut1 (.clk(clk), .reset(rst1), .bus(b1.slave));
    exc_seq #(.MEM_LATENCY(3)) u_dut3 (.clk(clk), .reset(rst3), .bus(b3.slave));

    // Expected-output builders for each sequencer phase.
    function automatic exp_t idl(input logic [2:0] io, input logic [1:0] c);
        return '{iord: io, mr: 1'b0, mw: 1'b0, ew: 1'b0, pw: 1'b0, ps: 1'b0,
                 hold: 1'b0, cause: c, done: 1'b0};
    endfunction
    function automatic exp_t epc(input logic [1:0] c);
        return '{iord: 3'b000, mr: 1'b0, mw: 1'b0, ew: 1'b1, pw: 1'b0, ps: 1'b0,
                 hold: 1'b1, cause: c, done: 1'b0};
    endfunction
    function automatic exp_t vrd(input logic [2:0] v, input logic [1:0] c);
        return '{iord: v, mr: 1'b1, mw: 1'b0, ew: 1'b0, pw: 1'b0, ps: 1'b0,
                 hold: 1'b1, cause: c, done: 1'b0};
    endfunction
    function automatic exp_t vwt(input logic [2:0] v, input logic [1:0] c, input logic m);
        return '{iord: v, mr: 1'b1, mw: m, ew: 1'b0, pw: 1'b0, ps: 1'b0,
                 hold: 1'b1, cause: c, done: 1'b0};
    endfunction
    function automatic exp_t ldp(input logic [1:0] c);
        return '{iord: 3'b000, mr: 1'b0, mw: 1'b0, ew: 1'b0, pw: 1'b1, ps: 1'b1,
                 hold: 1'b1, cause: c, done: 1'b1};
    endfunction

    // One stimulus cycle for instance sel (1 or 3); expectation covers this cycle.
    task automatic drv(input int sel, input logic r, input logic [2:0] c,
                       input logic o, input logic v, input logic d, input exp_t e);
        @(posedge clk);
        #1;
        step++;
        if (sel == 1) begin
            rst1 = r; b1.ctrl_iordmux = c;
            b1.exc_opcode = o; b1.exc_overflow = v; b1.exc_div0 = d;
            q1.push_back('{tag: step, e: e});
        end else begin
            rst3 = r; b3.ctrl_iordmux = c;
            b3.exc_opcode = o; b3.exc_overflow = v; b3.exc_div0 = d;
            q3.push_back('{tag: step, e: e});
        end
    endtask

    exp_t  m_a1, m_a3;
    item_t m_i1, m_i3;

    // Monitor: sample mid-cycle and compare against the scoreboard heads.
    always @(negedge clk) begin
        if (q1.size() != 0) begin
            m_i1 = q1.pop_front();
            m_a1 = '{iord: b1.iordmux, mr: b1.mem_read, mw: b1.mdr_write,
                     ew: b1.epc_write, pw: b1.pc_write, ps: b1.pc_src_exc,
                     hold: b1.ctrl_hold, cause: b1.cause, done: b1.exc_done};
            n_cmp++;
            if (m_a1 !== m_i1.e) begin
                n_bad++;
                $display("FAIL lat1 step%0d: got iord/mr/mw/ew/pw/ps/hold/cause/done=%b, expected %b",
                         m_i1.tag, m_a1, m_i1.e);
            end
        end
        if (q3.size() != 0) begin
            m_i3 = q3.pop_front();
            m_a3 = '{iord: b3.iordmux, mr: b3.mem_read, mw: b3.mdr_write,
                     ew: b3.epc_write, pw: b3.pc_write, ps: b3.pc_src_exc,
                     hold: b3.ctrl_hold, cause: b3.cause, done: b3.exc_done};
            n_cmp++;
            if (m_a3 !== m_i3.e) begin
                n_bad++;
                $display("FAIL lat3 step%0d: got iord/mr/mw/ew/pw/ps/hold/cause/done=%b, expected %b",
                         m_i3.tag, m_a3, m_i3.e);
            end
        end
    end

    initial begin
        rst1 = 1'b1; rst3 = 1'b1;
        b1.ctrl_iordmux = 3'b000; b1.exc_opcode = 1'b0; b1.exc_overflow = 1'b0; b1.exc_div0 = 1'b0;
        b3.ctrl_iordmux = 3'b000; b3.exc_opcode = 1'b0; b3.exc_overflow = 1'b0; b3.exc_div0 = 1'b0;
        repeat (2) @(posedge clk);

        // ---- MEM_LATENCY = 1 ----  args: sel, rst, ctrl, opc, ovf, div0, expected
        drv(1, 1, 3'b001, 0, 0, 0, idl(3'b001, 2'b00));   // reset state, pass-through
        drv(1, 0, 3'b001, 0, 0, 0, idl(3'b001, 2'b00));
        drv(1, 0, 3'b111, 0, 0, 0, idl(3'b000, 2'b00));   // 111 forced to 000
        drv(1, 0, 3'b110, 0, 0, 0, idl(3'b000, 2'b00));   // 110 forced to 000
        drv(1, 0, 3'b101, 0, 0, 0, idl(3'b101, 2'b00));
        // overflow pulse sampled at edge T (end of next row)
        drv(1, 0, 3'b010, 0, 1, 0, idl(3'b010, 2'b00));
        drv(1, 0, 3'b001, 0, 0, 0, epc(2'b10));          // T+1
        drv(1, 0, 3'b001, 0, 0, 0, vrd(3'b100, 2'b10));  // T+2
        drv(1, 0, 3'b001, 0, 0, 0, vwt(3'b100, 2'b10, 1)); // T+3
        drv(1, 0, 3'b001, 0, 0, 0, ldp(2'b10));          // T+4
        drv(1, 0, 3'b001, 0, 0, 0, idl(3'b001, 2'b10));  // cause held
        // opcode + div0 together: opcode wins
        drv(1, 0, 3'b000, 1, 0, 1, idl(3'b000, 2'b10));
        drv(1, 0, 3'b000, 0, 0, 0, epc(2'b01));
        drv(1, 0, 3'b000, 0, 0, 0, vrd(3'b011, 2'b01));
        drv(1, 0, 3'b000, 0, 0, 0, vwt(3'b011, 2'b01, 1));
        drv(1, 0, 3'b000, 1, 0, 0, ldp(2'b01));          // event during LOAD_PC ignored
        // event in the first IDLE cycle after the sequence is accepted
        drv(1, 0, 3'b000, 0, 0, 1, idl(3'b000, 2'b01));
        drv(1, 0, 3'b000, 0, 0, 0, epc(2'b11));
        drv(1, 0, 3'b000, 0, 0, 0, vrd(3'b101, 2'b11));
        drv(1, 0, 3'b000, 0, 0, 0, vwt(3'b101, 2'b11, 1));
        drv(1, 0, 3'b000, 0, 0, 0, ldp(2'b11));
        drv(1, 0, 3'b000, 0, 0, 0, idl(3'b000, 2'b11));
        // reset asserted during VEC_RD
        drv(1, 0, 3'b000, 0, 1, 0, idl(3'b000, 2'b11));
        drv(1, 0, 3'b000, 0, 0, 0, epc(2'b10));
        drv(1, 1, 3'b010, 0, 0, 0, vrd(3'b100, 2'b10));
        drv(1, 0, 3'b010, 0, 0, 0, idl(3'b010, 2'b00));
        drv(1, 0, 3'b100, 0, 0, 0, idl(3'b100, 2'b00));

        // ---- MEM_LATENCY = 3 ----
        drv(3, 1, 3'b000, 0, 0, 0, idl(3'b000, 2'b00));
        drv(3, 0, 3'b000, 0, 0, 1, idl(3'b000, 2'b00));   // div0 sampled at T
        drv(3, 0, 3'b000, 0, 0, 0, epc(2'b11));           // T+1
        drv(3, 0, 3'b000, 0, 0, 0, vrd(3'b101, 2'b11));   // T+2
        drv(3, 0, 3'b000, 0, 0, 0, vwt(3'b101, 2'b11, 0)); // T+3
        drv(3, 0, 3'b000, 1, 0, 0, vwt(3'b101, 2'b11, 0)); // T+4, opcode ignored
        drv(3, 0, 3'b000, 0, 0, 0, vwt(3'b101, 2'b11, 1)); // T+5
        drv(3, 0, 3'b000, 0, 0, 0, ldp(2'b11));           // T+6
        drv(3, 0, 3'b011, 0, 0, 0, idl(3'b011, 2'b11));
        drv(3, 0, 3'b000, 0, 0, 0, idl(3'b000, 2'b11));   // no second sequence

        @(negedge clk);
        #1;
        n_cmp++;
        if (q1.size() + q3.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q1.size() + q3.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
